seg_scan_driver: RTL and testbench

Multiplexed 4-digit seven-segment display driver. It is the stage directly downstream of the timekeeping counter chain: it consumes the BCD digits those counters produce and scans them onto common-anode displays. The mod-6 counter's 3-bit CNT feeds one digit zero-extended to 4 bits; the mod-10 counters feed the others. It snapshots all digits once per frame to prevent tearing, blanks leading zeros on request, and inserts a ghosting guard interval at the start of every digit slot.

---
 rtl/seg_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Multiplexed 4-digit common-anode seven-segment driver. Digits are BCD
// values taken from the upstream timekeeping counters. All four digits, the
// decimal-point requests and the leading-zero-blank flag are snapshotted once
// per frame, so a counter rollover mid-frame never produces a torn display.
// Every digit slot begins with a short guard interval with all anodes off to
// suppress ghosting between neighbouring digits.
//
// Parameters
//   SCAN_DIV      enabled clock cycles per digit slot (2..65535)
//   BLANK_CYCLES  guard cycles at the start of each slot (1..SCAN_DIV-1)
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-high reset
//   EN     in   scan enable; when low, everything holds and the display is dark
//   DIN    in   [15:0] four BCD digits, DIN[3:0] = digit 0 (rightmost)
//   DP     in   [3:0]  decimal point request per digit, 1 = lit
//   LZB    in   leading-zero blanking enable
//   AN     out  [3:0]  anode select, active-low, AN[i] drives digit i
//   SEG    out  [6:0]  segments, active-low, {g,f,e,d,c,b,a}
//   DP_N   out  decimal point, active-low
//   FRAME  out  one-cycle pulse at the start of each frame (slot 0, PCNT=0)
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] DIN,
    input  logic [3:0]  DP,
    input  logic        LZB,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP_N,
    output logic        FRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(BLANK_CYCLES);

    // Active-low gfedcba patterns; codes 10..15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // State
    logic [PW-1:0] pcnt_reg,  pcnt_next;
    logic [1:0]    idx_reg,   idx_next;
    logic [15:0]   s_din_reg, s_din_next;
    logic [3:0]    s_dp_reg,  s_dp_next;
    logic          s_lzb_reg, s_lzb_next;

    // Registered outputs
    logic [3:0]    an_reg,    an_next;
    logic [6:0]    seg_reg,   seg_next;
    logic          dp_n_reg,  dp_n_next;
    logic          frame_reg, frame_next;

    logic          slot_wrap;
    logic          snapshot;

    // Per-digit views of the next-state shadow contents
    logic [3:0]    digit [4];
    logic [3:0]    lz_blank;

    // -----------------------------------------------------------------------
    // Scan counters and frame snapshot
    // -----------------------------------------------------------------------
    always_comb begin
        pcnt_next  = pcnt_reg;
        idx_next   = idx_reg;
        s_din_next = s_din_reg;
        s_dp_next  = s_dp_reg;
        s_lzb_next = s_lzb_reg;
        slot_wrap  = 1'b0;
        snapshot   = 1'b0;

        if (EN) begin
            slot_wrap = (pcnt_reg == PCNT_LAST);
            pcnt_next = slot_wrap ? '0 : pcnt_reg + 1'b1;
            if (slot_wrap) begin
                idx_next = idx_reg + 2'd1;
            end
            // The 3->0 digit wrap is the frame boundary: latch a coherent
            // copy of every input used for display in the coming frame.
            snapshot = slot_wrap && (idx_reg == 2'd3);
            if (snapshot) begin
                s_din_next = DIN;
                s_dp_next  = DP;
                s_lzb_next = LZB;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero detection: digit gi (gi >= 1) is blanked when it and every
    // digit above it are zero. Digit 0 always shows.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi] = s_din_next[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = s_lzb_next && (s_din_next[15:4*gi] == '0);
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output decode from next-state values, so the registered outputs line up
    // with the counters and shadows that will be current after this edge.
    // -----------------------------------------------------------------------
    always_comb begin
        an_next    = 4'b1111;
        seg_next   = 7'b1111111;
        dp_n_next  = 1'b1;
        frame_next = EN && snapshot;

        if (EN && (pcnt_next >= GUARD_END) && !lz_blank[idx_next]) begin
            an_next   = ~(4'b0001 << idx_next);
            seg_next  = bcd_to_seg(digit[idx_next]);
            dp_n_next = ~s_dp_next[idx_next];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt_reg  <= '0;
            idx_reg   <= 2'd0;
            s_din_reg <= 16'h0000;
            s_dp_reg  <= 4'b0000;
            s_lzb_reg <= 1'b0;
            an_reg    <= 4'b1111;
            seg_reg   <= 7'b1111111;
            dp_n_reg  <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            pcnt_reg  <= pcnt_next;
            idx_reg   <= idx_next;
            s_din_reg <= s_din_next;
            s_dp_reg  <= s_dp_next;
            s_lzb_reg <= s_lzb_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_n_reg  <= dp_n_next;
            frame_reg <= frame_next;
        end
    end

    assign AN    = an_reg;
    assign SEG   = seg_reg;
    assign DP_N  = dp_n_reg;
    assign FRAME = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Scoreboard bench for seg_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1.
// The stimulus process drives one clock edge at a time and pushes the
// expected {AN, SEG, DP_N, FRAME} for the cycle after that edge; directed
// points carry hand-computed values, the remaining cycles use a small
// frame-position model (enabled-edge count modulo the frame length).
// A monitor pops one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FR = 4 * SD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b0;
    logic [15:0] DIN = 16'h0000;
    logic [3:0]  DP  = 4'b0000;
    logic        LZB = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP_N;
    logic        FRAME;

    seg_scan_driver #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .DIN   (DIN),
        .DP    (DP),
        .LZB   (LZB),
        .AN    (AN),
        .SEG   (SEG),
        .DP_N  (DP_N),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc   = 0;

    int          m_n;
    logic [15:0] m_sdin;
    logic [3:0]  m_sdp;
    logic        m_slzb;

    function automatic logic [12:0] pk(input logic [3:0] an, input logic [6:0] seg,
                                       input logic dpn, input logic fr);
        return {an, seg, dpn, fr};
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_sdin = 16'h0000;
        m_sdp  = 4'b0000;
        m_slzb = 1'b0;
    endtask

    // Drive inputs, take one clock edge, push the expected output for the
    // following cycle. A non-empty name selects the hand-computed value hx.
    task automatic step(input logic en, input logic [15:0] din, input logic [3:0] dp,
                        input logic lzb, input string nm, input logic [12:0] hx);
        exp_t        e;
        logic        fr;
        int          ix;
        int          pc;
        logic [12:0] mx;
        EN  = en;
        DIN = din;
        DP  = dp;
        LZB = lzb;
        @(posedge CLK);
        #1;
        n_cyc++;
        fr = 1'b0;
        mx = pk(4'hF, 7'h7F, 1'b1, 1'b0);
        if (en) begin
            m_n = (m_n + 1) % FR;
            if (m_n == 0) begin
                m_sdin = din;
                m_sdp  = dp;
                m_slzb = lzb;
                fr     = 1'b1;
            end
            ix = m_n / SD;
            pc = m_n % SD;
            if (pc >= BC && !(m_slzb && ix >= 1 && (m_sdin >> (4 * ix)) == 16'h0000))
                mx = pk(~(4'b0001 << ix), ref_seg(m_sdin[4*ix +: 4]), ~m_sdp[ix], fr);
            else
                mx = pk(4'hF, 7'h7F, 1'b1, fr);
        end
        if (nm != "") begin
            e.exp  = hx;
            e.name = nm;
        end else begin
            e.exp  = mx;
            e.name = $sformatf("model_c%0d", n_cyc);
        end
        sb_q.push_back(e);
    endtask

    task automatic run(input logic en, input logic [15:0] din, input logic [3:0] dp,
                       input logic lzb);
        step(en, din, dp, lzb, "", 13'h0);
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending.
    initial begin
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_tests++;
                if ({AN, SEG, DP_N, FRAME} !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got an=%b seg=%b dp_n=%b frame=%b, expected an=%b seg=%b dp_n=%b frame=%b",
                             e.name, AN, SEG, DP_N, FRAME,
                             e.exp[12:9], e.exp[8:2], e.exp[1], e.exp[0]);
                end else begin
                    $display("[TB] ok %s an=%b seg=%b dp_n=%b frame=%b",
                             e.name, AN, SEG, DP_N, FRAME);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] din_v;
        logic [3:0]  dp_v;
        logic        lzb_v;
        string       nm;
        logic [12:0] hx;

        model_reset();
        din_v = 16'h0305;
        dp_v  = 4'b0000;
        lzb_v = 1'b0;

        // Reset state while RST is held
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if ({AN, SEG, DP_N, FRAME} !== pk(4'hF, 7'h7F, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state: got an=%b seg=%b dp_n=%b frame=%b, expected an=1111 seg=1111111 dp_n=1 frame=0",
                     AN, SEG, DP_N, FRAME);
        end else begin
            $display("[TB] ok reset_state");
        end
        #2 RST = 1'b0;

        for (int e = 1; e <= 117; e++) begin
            if (e == 38) begin din_v = 16'h0999; lzb_v = 1'b1; end
            if (e == 52) din_v = 16'h0005;
            if (e == 70) din_v = 16'h0000;
            if (e == 85) begin din_v = 16'h00A0; dp_v = 4'b0010; lzb_v = 1'b0; end

            nm = "";
            hx = 13'h0;
            case (e)
                3:   begin nm = "a_e3_digit0_zero";       hx = pk(4'b1110, 7'b1000000, 1'b1, 1'b0); end
                16:  begin nm = "a_e16_frame_guard";      hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b1); end
                17:  begin nm = "a_e17_slot0_five";       hx = pk(4'b1110, 7'b0010010, 1'b1, 1'b0); end
                18:  begin nm = "a_e18_slot0_five";       hx = pk(4'b1110, 7'b0010010, 1'b1, 1'b0); end
                19:  begin nm = "a_e19_slot0_five";       hx = pk(4'b1110, 7'b0010010, 1'b1, 1'b0); end
                21:  begin nm = "a_slot1_zero";           hx = pk(4'b1101, 7'b1000000, 1'b1, 1'b0); end
                25:  begin nm = "a_slot2_three";          hx = pk(4'b1011, 7'b0110000, 1'b1, 1'b0); end
                29:  begin nm = "a_slot3_zero";           hx = pk(4'b0111, 7'b1000000, 1'b1, 1'b0); end
                39:  begin nm = "c_midframe_din_ignored"; hx = pk(4'b1101, 7'b1000000, 1'b1, 1'b0); end
                41:  begin nm = "c_slot2_keeps_three";    hx = pk(4'b1011, 7'b0110000, 1'b1, 1'b0); end
                57:  begin nm = "c_new_frame_nine";       hx = pk(4'b1011, 7'b0010000, 1'b1, 1'b0); end
                61:  begin nm = "c_digit3_lzb_blank";     hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b0); end
                65:  begin nm = "b_lzb_digit0_five";      hx = pk(4'b1110, 7'b0010010, 1'b1, 1'b0); end
                70:  begin nm = "b_lzb_slot1_blank";      hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b0); end
                82:  begin nm = "b_all_zero_digit0";      hx = pk(4'b1110, 7'b1000000, 1'b1, 1'b0); end
                86:  begin nm = "b_all_zero_slot1_blank"; hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b0); end
                97:  begin nm = "d_slot0_dp_off";         hx = pk(4'b1110, 7'b1000000, 1'b1, 1'b0); end
                100: begin nm = "d_guard_dp_off";         hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b0); end
                101: begin nm = "d_dash_dp_on";           hx = pk(4'b1101, 7'b0111111, 1'b0, 1'b0); end
                107: begin nm = "e_resume_slot2_pcnt3";   hx = pk(4'b1011, 7'b1000000, 1'b1, 1'b0); end
                108: begin nm = "e_slot3_guard";          hx = pk(4'b1111, 7'b1111111, 1'b1, 1'b0); end
                109: begin nm = "e_slot3_active";         hx = pk(4'b0111, 7'b1000000, 1'b1, 1'b0); end
                default: ;
            endcase
            step(1'b1, din_v, dp_v, lzb_v, nm, hx);

            // Pause the scan at slot 2, PCNT=2 for ten cycles
            if (e == 106) begin
                for (int k = 0; k < 10; k++) begin
                    if (k == 0)
                        step(1'b0, din_v, dp_v, lzb_v, "e_en_low_blank", pk(4'hF, 7'h7F, 1'b1, 1'b0));
                    else
                        run(1'b0, din_v, dp_v, lzb_v);
                end
            end
        end

        // Asynchronous reset mid-slot 1 (display currently shows a lit dash + DP)
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if ({AN, SEG, DP_N, FRAME} !== pk(4'hF, 7'h7F, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL async_reset: got an=%b seg=%b dp_n=%b frame=%b, expected an=1111 seg=1111111 dp_n=1 frame=0",
                     AN, SEG, DP_N, FRAME);
        end else begin
            $display("[TB] ok async_reset");
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        model_reset();

        // After reset the shadows are cleared: 0000 with no blanking until
        // the first snapshot, even though LZB is now requested.
        for (int e = 1; e <= 15; e++) begin
            nm = "";
            hx = 13'h0;
            if (e == 1) begin nm = "r_post_reset_digit0"; hx = pk(4'b1110, 7'b1000000, 1'b1, 1'b0); end
            if (e == 5) begin nm = "r_post_reset_digit1"; hx = pk(4'b1101, 7'b1000000, 1'b1, 1'b0); end
            step(1'b1, 16'h0999, 4'b0000, 1'b1, nm, hx);
        end
        // EN low on what would have been the snapshot edge: nothing happens
        step(1'b0, 16'h0123, 4'b0000, 1'b1, "s_snap_edge_en_low", pk(4'hF, 7'h7F, 1'b1, 1'b0));
        step(1'b1, 16'h0123, 4'b0000, 1'b1, "s_frame_after_resume", pk(4'hF, 7'h7F, 1'b1, 1'b1));
        step(1'b1, 16'h0123, 4'b0000, 1'b1, "s_new_digit0_three", pk(4'b1110, 7'b0110000, 1'b1, 1'b0));
        run(1'b1, 16'h0123, 4'b0000, 1'b1);
        run(1'b1, 16'h0123, 4'b0000, 1'b1);

        @(negedge CLK);
        @(posedge CLK);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
